// File: rtl/dram_phase_gen_pkg.sv
// dram_phase_gen shared types and constants
// VIC cycle encodings, phase counter sizing, helpers
package dram_phase_gen_pkg;

  localparam int PHASE_W         = 4;
  localparam int PHASES_PER_HALF = 16;
  localparam int REFC_W          = 8;

  typedef enum logic [3:0] {
    VIC_LP   = 4'd0,
    VIC_LPI2 = 4'd1,
    VIC_LI   = 4'd2,
    VIC_LR   = 4'd3,
    VIC_LG   = 4'd4,
    VIC_HS1  = 4'd5,
    VIC_HPI1 = 4'd6,
    VIC_HPI2 = 4'd7,
    VIC_HSS  = 4'd8,
    VIC_HPL  = 4'd9,
    VIC_HRI  = 4'd10,
    VIC_HRC  = 4'd11,
    VIC_HGC  = 4'd12,
    VIC_HGI  = 4'd13,
    VIC_HI   = 4'd14,
    VIC_HS3  = 4'd15
  } vic_cycle_t;

  function automatic logic phase_in_range(
    input int p
  );
    return (p >= 0) && (p < PHASES_PER_HALF);
  endfunction

  function automatic logic phase_order_ok(
    input int row,
    input int rhl,
    input int col,
    input int chl,
    input int rlh,
    input int clh
  );
    logic ok;
    ok = phase_in_range(row) &&
         phase_in_range(rhl) &&
         phase_in_range(col) &&
         phase_in_range(chl) &&
         phase_in_range(rlh) &&
         phase_in_range(clh);
    ok = ok && (row < rhl);
    ok = ok && (rhl < col);
    ok = ok && (col < chl);
    ok = ok && (rlh > chl);
    ok = ok && (clh > chl);
    return ok;
  endfunction

endpackage

// File: rtl/dram_phase_gen_phase_strobe.sv
// dram_phase_gen single phase strobe
// Registered match of the next phase against PHASE
module dram_phase_gen_phase_strobe
  import dram_phase_gen_pkg::*;
#(
  parameter logic [PHASE_W-1:0] PHASE = '0
) (
  input  logic               clk_dot4x,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] i_next_phase,
  output logic               o_strobe
);

  logic r_strobe;
  logic w_hit;

  assign w_hit = (i_next_phase == PHASE);

  // high for the one tick whose registered phase equals PHASE
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_hit;
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/dram_phase_gen.sv
// dram_phase_gen: PHI/phase timing master
// Phase strobes for RAS/CAS plus refresh counter
module dram_phase_gen
  import dram_phase_gen_pkg::*;
#(
  parameter int          ROW_PHASE = 3,
  parameter int          RHL_PHASE = 5,
  parameter int          COL_PHASE = 6,
  parameter int          CHL_PHASE = 7,
  parameter int          RLH_PHASE = 15,
  parameter int          CLH_PHASE = 15,
  parameter logic [7:0]  REFC_INIT = 8'hFF
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic [3:0] cycle_type,
  input  logic       line_start,
  output logic       phi,
  output logic [3:0] phase,
  output logic       phi_phase_start_row,
  output logic       phi_phase_start_col,
  output logic       phi_phase_start_rhl,
  output logic       phi_phase_start_rlh,
  output logic       phi_phase_start_chl,
  output logic       phi_phase_start_clh,
  output logic       dot_start,
  output logic       half_end,
  output logic [7:0] refc
);

  localparam logic [PHASE_W-1:0] LAST =
    PHASE_W'(PHASES_PER_HALF - 1);

  if (!phase_order_ok(ROW_PHASE, RHL_PHASE,
                      COL_PHASE, CHL_PHASE,
                      RLH_PHASE, CLH_PHASE))
  begin : g_bad_phase_order
    $fatal(1, "dram_phase_gen: bad phase order");
  end

  logic               r_run;
  logic [PHASE_W-1:0] r_phase;
  logic               r_phi;
  logic               r_dot_start;
  logic               r_half_end;
  logic [REFC_W-1:0]  r_refc;

  logic [PHASE_W-1:0] w_next_phase;
  logic               w_next_phi;
  logic               w_wrap;
  logic               w_refresh;

  // first tick out of reset holds phase 0 so it is seen once
  assign w_wrap       = r_run && (r_phase == LAST);
  assign w_next_phase = r_run ? r_phase + 4'd1 : r_phase;
  assign w_next_phi   = r_phi ^ w_wrap;

  assign w_refresh = !r_phi &&
                     (r_phase == LAST) &&
                     (cycle_type == VIC_LR);

  // phase / phi counter
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_phase <= '0;
      r_phi   <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_phase <= w_next_phase;
      r_phi   <= w_next_phi;
    end
  end

  // dot and half-cycle markers decoded from next phase
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_dot_start <= 1'b0;
      r_half_end  <= 1'b0;
    end else begin
      r_dot_start <= (w_next_phase[1:0] == 2'd0);
      r_half_end  <= (w_next_phase == LAST);
    end
  end

  // refresh counter: line reload beats LR decrement
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_refc <= REFC_INIT;
    end else if (line_start) begin
      r_refc <= REFC_INIT;
    end else if (w_refresh) begin
      r_refc <= r_refc - 8'd1;
    end
  end

  dram_phase_gen_phase_strobe #(
    .PHASE (PHASE_W'(ROW_PHASE))
  ) u_row (
    .clk_dot4x    (clk_dot4x),
    .rst_n        (rst_n),
    .i_next_phase (w_next_phase),
    .o_strobe     (phi_phase_start_row)
  );

  dram_phase_gen_phase_strobe #(
    .PHASE (PHASE_W'(RHL_PHASE))
  ) u_rhl (
    .clk_dot4x    (clk_dot4x),
    .rst_n        (rst_n),
    .i_next_phase (w_next_phase),
    .o_strobe     (phi_phase_start_rhl)
  );

  dram_phase_gen_phase_strobe #(
    .PHASE (PHASE_W'(COL_PHASE))
  ) u_col (
    .clk_dot4x    (clk_dot4x),
    .rst_n        (rst_n),
    .i_next_phase (w_next_phase),
    .o_strobe     (phi_phase_start_col)
  );

  dram_phase_gen_phase_strobe #(
    .PHASE (PHASE_W'(CHL_PHASE))
  ) u_chl (
    .clk_dot4x    (clk_dot4x),
    .rst_n        (rst_n),
    .i_next_phase (w_next_phase),
    .o_strobe     (phi_phase_start_chl)
  );

  dram_phase_gen_phase_strobe #(
    .PHASE (PHASE_W'(RLH_PHASE))
  ) u_rlh (
    .clk_dot4x    (clk_dot4x),
    .rst_n        (rst_n),
    .i_next_phase (w_next_phase),
    .o_strobe     (phi_phase_start_rlh)
  );

  dram_phase_gen_phase_strobe #(
    .PHASE (PHASE_W'(CLH_PHASE))
  ) u_clh (
    .clk_dot4x    (clk_dot4x),
    .rst_n        (rst_n),
    .i_next_phase (w_next_phase),
    .o_strobe     (phi_phase_start_clh)
  );

  assign phi       = r_phi;
  assign phase     = r_phase;
  assign dot_start = r_dot_start;
  assign half_end  = r_half_end;
  assign refc      = r_refc;

endmodule

// File: tb/tb_dram_phase_gen.sv
// tb_dram_phase_gen: scoreboard + vector table
// Tick-count reference model of phase/refc
module tb_dram_phase_gen;
  import dram_phase_gen_pkg::*;

  localparam int P_ROW = 3;
  localparam int P_RHL = 5;
  localparam int P_COL = 6;
  localparam int P_CHL = 7;
  localparam int P_RLH = 15;
  localparam int P_CLH = 15;
  localparam logic [7:0] P_INIT = 8'hFF;

  typedef struct packed {
    logic       phi;
    logic [3:0] phase;
    logic       row;
    logic       rhl;
    logic       col;
    logic       chl;
    logic       rlh;
    logic       clh;
    logic       dot;
    logic       hend;
    logic [7:0] refc;
  } obs_t;

  typedef struct {
    logic [3:0] ct;
    logic       ls;
    int         n;
    logic [7:0] refc;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] cycle_type;
  logic       line_start;
  logic       phi;
  logic [3:0] phase;
  logic       s_row, s_col, s_rhl;
  logic       s_rlh, s_chl, s_clh;
  logic       dot_start;
  logic       half_end;
  logic [7:0] refc;

  dram_phase_gen dut (
    .clk_dot4x           (clk),
    .rst_n               (rst_n),
    .cycle_type          (cycle_type),
    .line_start          (line_start),
    .phi                 (phi),
    .phase               (phase),
    .phi_phase_start_row (s_row),
    .phi_phase_start_col (s_col),
    .phi_phase_start_rhl (s_rhl),
    .phi_phase_start_rlh (s_rlh),
    .phi_phase_start_chl (s_chl),
    .phi_phase_start_clh (s_clh),
    .dot_start           (dot_start),
    .half_end            (half_end),
    .refc                (refc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_tick   = 0;
  obs_t q[$];
  obs_t m_pop;

  bit         m_started;
  int         m_phase;
  bit         m_phi;
  logic [7:0] m_refc;

  vec_t tbl [20];

  function automatic obs_t dut_obs();
    obs_t o;
    o.phi   = phi;
    o.phase = phase;
    o.row   = s_row;
    o.rhl   = s_rhl;
    o.col   = s_col;
    o.chl   = s_chl;
    o.rlh   = s_rlh;
    o.clh   = s_clh;
    o.dot   = dot_start;
    o.hend  = half_end;
    o.refc  = refc;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.phi   = m_phi;
    o.phase = 4'(m_phase);
    o.row   = (m_phase == P_ROW);
    o.rhl   = (m_phase == P_RHL);
    o.col   = (m_phase == P_COL);
    o.chl   = (m_phase == P_CHL);
    o.rlh   = (m_phase == P_RLH);
    o.clh   = (m_phase == P_CLH);
    o.dot   = (m_phase % 4 == 0);
    o.hend  = (m_phase == 15);
    o.refc  = m_refc;
    return o;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_phase   = 0;
    m_phi     = 0;
    m_refc    = P_INIT;
  endtask

  task automatic model_step(input logic [3:0] ct,
                            input logic ls);
    if (ls)
      m_refc = P_INIT;
    else if (!m_phi && m_phase == 15 && ct == VIC_LR)
      m_refc = m_refc - 8'd1;
    if (!m_started) begin
      m_started = 1;
    end else if (m_phase == 15) begin
      m_phase = 0;
      m_phi   = !m_phi;
    end else begin
      m_phase = m_phase + 1;
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h t=%0t",
                  name, act, exp, $time);
  endtask

  task automatic step(input logic [3:0] ct,
                      input logic ls);
    @(negedge clk);
    cycle_type = ct;
    line_start = ls;
    model_step(ct, ls);
    q.push_back(model_obs());
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_pop = q.pop_front();
      n_tick++;
      chk($sformatf("sb tick%0d", n_tick),
          32'(dut_obs()), 32'(m_pop));
    end
  end

  initial begin
    obs_t zero;
    zero = '0;
    zero.refc = P_INIT;

    tbl[0]  = '{VIC_LP, 1'b0, 1,    8'hFF};
    tbl[1]  = '{VIC_LR, 1'b0, 16,   8'hFE};
    tbl[2]  = '{VIC_LR, 1'b0, 16,   8'hFE};
    tbl[3]  = '{VIC_LR, 1'b0, 16,   8'hFD};
    tbl[4]  = '{VIC_LR, 1'b0, 16,   8'hFD};
    tbl[5]  = '{VIC_LR, 1'b0, 16,   8'hFC};
    tbl[6]  = '{VIC_LR, 1'b0, 16,   8'hFC};
    tbl[7]  = '{VIC_LR, 1'b0, 16,   8'hFB};
    tbl[8]  = '{VIC_LR, 1'b0, 16,   8'hFB};
    tbl[9]  = '{VIC_LR, 1'b0, 16,   8'hFA};
    tbl[10] = '{VIC_LR, 1'b0, 16,   8'hFA};
    tbl[11] = '{VIC_LP, 1'b1, 16,   8'hFF};
    tbl[12] = '{VIC_LR, 1'b0, 16,   8'hFF};
    tbl[13] = '{VIC_LP, 1'b0, 16,   8'hFF};
    tbl[14] = '{VIC_LR, 1'b0, 16,   8'hFF};
    tbl[15] = '{VIC_LR, 1'b0, 8160, 8'h00};
    tbl[16] = '{VIC_LR, 1'b0, 16,   8'hFF};
    tbl[17] = '{VIC_LP, 1'b0, 16,   8'hFF};
    tbl[18] = '{VIC_LR, 1'b0, 6112, 8'h40};
    tbl[19] = '{VIC_LR, 1'b1, 16,   8'hFF};

    rst_n      = 1'b0;
    cycle_type = VIC_LP;
    line_start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(dut_obs()), 32'(zero));
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < tbl[i].n; j++)
        step(tbl[i].ct,
             tbl[i].ls && (j == tbl[i].n - 1));
      chk($sformatf("tbl%0d_refc", i),
          32'(refc), 32'(tbl[i].refc));
    end

    repeat (9) step(VIC_LP, 1'b0);
    chk("pre_rst_phase", 32'(phase), 32'd9);
    chk("pre_rst_phi", 32'(phi), 32'd1);

    rst_n = 1'b0;
    #1;
    chk("mid_rst_now", 32'(dut_obs()), 32'(zero));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mid_rst_hold%0d", k),
          32'(dut_obs()), 32'(zero));
    end
    #1;
    rst_n = 1'b1;
    model_reset();

    step(VIC_LR, 1'b0);
    chk("rel_phase0", 32'(phase), 32'd0);
    chk("rel_phi0", 32'(phi), 32'd0);
    chk("rel_dot", 32'(dot_start), 32'd1);
    for (int k = 0; k < 40; k++)
      step(VIC_LR, 1'b0);
    chk("rel_refc", 32'(refc), 32'hFE);

    @(posedge clk);
    #3;
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_phase_gen.md
Name: dram_phase_gen

Overview:
- Timing master for the DRAM/bus interface, clocked by clk_dot4x.
- Divides the dot4x clock into 16 phases per PHI half-cycle and produces PHI.
- Emits one-tick phase strobes that drive RAS/CAS edges and the row/column address mux in addressgen.
- Holds the 8-bit DRAM refresh counter (refc) consumed by addressgen during refresh cycles.

Parameters:
- ROW_PHASE, 3, phase (0..15) of phi_phase_start_row
- RHL_PHASE, 5, phase of phi_phase_start_rhl (RAS falls)
- COL_PHASE, 6, phase of phi_phase_start_col
- CHL_PHASE, 7, phase of phi_phase_start_chl (CAS falls)
- RLH_PHASE, 15, phase of phi_phase_start_rlh (RAS rises)
- CLH_PHASE, 15, phase of phi_phase_start_clh (CAS rises)
- REFC_INIT, 8'hFF, refresh counter reset/reload value

Ports:
- clk_dot4x  in  1  dot clock x4; the only clock
- rst_n  in  1  asynchronous, active-low reset
- cycle_type  in  4  current VIC cycle type (encodings from common.vh)
- line_start  in  1  one-tick pulse at raster line 0 start; reloads refc
- phi  out  1  0 = VIC half (low), 1 = CPU half (high)
- phase  out  4  phase index within the current half-cycle
- phi_phase_start_row  out  1  row-address strobe
- phi_phase_start_col  out  1  column-address strobe
- phi_phase_start_rhl  out  1  RAS high-to-low strobe
- phi_phase_start_rlh  out  1  RAS low-to-high strobe
- phi_phase_start_chl  out  1  CAS high-to-low strobe
- phi_phase_start_clh  out  1  CAS low-to-high strobe
- dot_start  out  1  high on the first tick of each dot (phase[1:0] == 0)
- half_end  out  1  high on phase 15 of either half
- refc  out  8  refresh counter

Behaviour:
- Reset (async assert, sync release): phase = 0, phi = 0, every strobe = 0, half_end = 0, dot_start = 0, refc = REFC_INIT.
- Counter:
  - phase increments by 1 every clk_dot4x tick and wraps 15 -> 0.
  - phi toggles on the same tick as the 15 -> 0 wrap.
  - Full PHI period = 32 ticks.
- All outputs are registered and decoded from the next-state counter, so each strobe is high exactly in the tick where the registered phase equals its parameter. This gives zero-latency alignment with the phase output.
- Strobe rules:
  - Each phase strobe fires once per half-cycle, in both halves (the DRAM is accessed in both halves), and is high for exactly one tick.
  - dot_start fires at phases 0, 4, 8 and 12.
- First tick after reset release: phase = 0 and dot_start = 1.
- Ordering:
  - ROW_PHASE < RHL_PHASE < COL_PHASE < CHL_PHASE is required.
  - RLH_PHASE and CLH_PHASE must be greater than CHL_PHASE; they may be equal to each other.
  - A simulation-only elaboration check reports a fatal error on violation. No runtime correction is applied.
- Refresh counter:
  - Decrement: on the tick where phi = 0, phase = 15 and cycle_type == VIC_LR, refc <= refc - 1 (modulo 256; 8'h00 -> 8'hFF).
  - cycle_type is sampled only on that tick.
  - line_start = 1 on any tick loads refc <= REFC_INIT. Reload wins over a simultaneous decrement.
  - No change in the phi = 1 half, whatever cycle_type is.
- Reset asserted mid-half-cycle: all outputs return to reset values immediately. No strobe may glitch high during reset.
- No other state; no handshakes. Downstream blocks must tolerate strobes in both halves.

Decomposition:
- common.vh: VIC_* cycle-type encodings (already present); add PHASE_W = 4 and PHASES_PER_HALF = 16.
- Single module. One small sub-module is natural: phase_strobe (registered comparator: next_phase == PARAM -> strobe), instantiated six times.

Test Plan:
- Reset release, free run 64 ticks:
  - phase sequence 0..15, 0..15.
  - phi = 0 for ticks 0-15, 1 for 16-31, 0 again at tick 32.
  - dot_start on ticks 0, 4, 8, 12, 16, ...
- Default parameters, each half-cycle:
  - row @ phase 3, rhl @ 5, col @ 6, chl @ 7, rlh and clh both @ 15.
  - Each strobe high exactly 1 tick, present in both phi halves.
- cycle_type = VIC_LR held for 5 low halves from reset: refc = FF, FE, FD, FC, FB. With VIC_LR only during the phi = 1 halves, refc stays FF.
- refc = 8'h00 plus an LR low half: refc = 8'hFF (wrap).
- line_start on the same tick as an LR decrement with refc = 8'h40: refc = 8'hFF (reload wins).
- rst_n asserted at phase 9 of a phi = 1 half: phase = 0, phi = 0 and all strobes 0 in the same tick. After release, the sequence restarts at phase 0 with phi = 0.
